// File: rtl/tick_gen_if.sv
// tick_gen_if: control and strobe signals of the tick generator.
// The generator drives clk_stb/sq/div_err; the controlling side drives
// en/sync and the runtime divisor load.
interface tick_gen_if #(
  parameter int WIDTH = 27
);
  logic             en;
  logic             sync;
  logic             div_load;
  logic [WIDTH-1:0] div_val;
  logic             clk_stb;
  logic             sq;
  logic             div_err;

  modport master (
    output en, sync, div_load, div_val,
    input  clk_stb, sq, div_err
  );

  modport slave (
    input  en, sync, div_load, div_val,
    output clk_stb, sq, div_err
  );
endinterface

// File: rtl/tick_gen.sv
// tick_gen: divides CLK100MHZ down to a one-cycle tick strobe (clk_stb) and a
// 50% square wave (sq) that toggles on each tick. cnt runs 0..div_r-1.
// Optional feature macro: TICK_GEN_RUNTIME_DIV_EN enables the runtime divisor
// load (div_load/div_val) and its error pulse (div_err). Without it the
// divisor stays at CLK_HZ/TICK_HZ and div_err is held low.
// All outputs are registered; no input reaches an output combinationally.
module tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int WIDTH   = 27
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  tick_gen_if.slave  tg
);

  localparam logic [WIDTH-1:0] DIV0 = WIDTH'(CLK_HZ / TICK_HZ);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_r;
  logic             load_ok;
  logic             load_bad;
  logic             wrap;

`ifdef TICK_GEN_RUNTIME_DIV_EN
  // Classify a load request: divisors below 2 are rejected.
  always_comb begin
    load_ok  = 1'b0;
    load_bad = 1'b0;
    if (tg.div_load) begin
      if (tg.div_val >= WIDTH'(2)) load_ok  = 1'b1;
      else                         load_bad = 1'b1;
    end
  end
`else
  logic unused_div;
  assign unused_div = ^{tg.div_load, tg.div_val};

  // Runtime loading disabled: the divisor never changes and nothing is rejected.
  always_comb begin
    load_ok  = 1'b0;
    load_bad = 1'b0;
  end
`endif

  // Terminal count reached on an enabled cycle.
  always_comb begin
    wrap = 1'b0;
    if (tg.en && (cnt == div_r - WIDTH'(1))) wrap = 1'b1;
  end

  // Counter, divisor and registered outputs. A restart (sync or accepted
  // load) takes priority over counting, so a coincident wrap is swallowed.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cnt        <= '0;
      div_r      <= DIV0;
      tg.clk_stb <= 1'b0;
      tg.sq      <= 1'b0;
      tg.div_err <= 1'b0;
    end else begin
      tg.clk_stb <= 1'b0;
      tg.div_err <= load_bad;
      if (tg.sync || load_ok) begin
        cnt <= '0;
        if (tg.sync) tg.sq <= 1'b0;
        if (load_ok) div_r <= tg.div_val;
      end else if (wrap) begin
        cnt        <= '0;
        tg.clk_stb <= 1'b1;
        tg.sq      <= ~tg.sq;
      end else if (tg.en) begin
        cnt <= cnt + WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed checks of tick_gen with CLK_HZ=10, TICK_HZ=1, WIDTH=8
// (reset divisor 10). Expectations for divisor loads follow whether
// TICK_GEN_RUNTIME_DIV_EN is defined for the build.
module tb_tick_gen;

  localparam int W = 8;

`ifdef TICK_GEN_RUNTIME_DIV_EN
  localparam bit RT = 1'b1;
`else
  localparam bit RT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  tick_gen_if #(.WIDTH(W)) tg ();

  tick_gen #(
    .CLK_HZ  (10),
    .TICK_HZ (1),
    .WIDTH   (W)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .tg         (tg.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    tg.en       = 1'b0;
    tg.sync     = 1'b0;
    tg.div_load = 1'b0;
    tg.div_val  = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b1;
    tg.en       = 1'b1;
    tg.sync     = 1'b0;
    tg.div_load = 1'b0;
    tg.div_val  = '0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tg.clk_stb, tg.sq, tg.div_err} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_outputs: got stb/sq/err=%b required 000", {tg.clk_stb, tg.sq, tg.div_err});
    end
    do_reset();
  endtask

  task automatic test_count();
    do_reset();
    tg.en = 1'b1;
    for (int e = 1; e <= 35; e++) begin
      step();
      n_cmp++;
      if (tg.clk_stb !== (e % 10 == 0)) begin
        n_err++;
        $display("FAIL count_stb edge %0d: got %b required %b", e, tg.clk_stb, (e % 10 == 0));
      end
      n_cmp++;
      if (tg.sq !== 1'((e / 10) % 2)) begin
        n_err++;
        $display("FAIL count_sq edge %0d: got %b required %b", e, tg.sq, 1'((e / 10) % 2));
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    tg.en = 1'b1;
    for (int e = 1; e <= 4; e++) step();
    tg.en = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      n_cmp++;
      if ({tg.clk_stb, tg.sq} !== 2'b00) begin
        n_err++;
        $display("FAIL enable_hold cycle %0d: got stb/sq=%b required 00", e, {tg.clk_stb, tg.sq});
      end
    end
    tg.en = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      n_cmp++;
      if (tg.clk_stb !== (e == 6)) begin
        n_err++;
        $display("FAIL enable_resume edge %0d: got %b required %b", e, tg.clk_stb, (e == 6));
      end
    end
  endtask

  task automatic test_sync();
    do_reset();
    tg.en = 1'b1;
    for (int e = 1; e <= 19; e++) step();
    n_cmp++;
    if (tg.sq !== 1'b1) begin
      n_err++;
      $display("FAIL sync_pre_sq: got %b required 1", tg.sq);
    end
    tg.sync = 1'b1;
    step();
    tg.sync = 1'b0;
    n_cmp++;
    if ({tg.clk_stb, tg.sq} !== 2'b00) begin
      n_err++;
      $display("FAIL sync_edge: got stb/sq=%b required 00", {tg.clk_stb, tg.sq});
    end
    for (int e = 1; e <= 10; e++) begin
      step();
      n_cmp++;
      if ({tg.clk_stb, tg.sq} !== {(e == 10), (e == 10)}) begin
        n_err++;
        $display("FAIL sync_after edge %0d: got stb/sq=%b required %b", e, {tg.clk_stb, tg.sq}, {(e == 10), (e == 10)});
      end
    end
  endtask

  task automatic test_runtime_div();
    logic exp_stb;
    logic exp_sq;
    do_reset();
    tg.en = 1'b1;
    for (int e = 1; e <= 7; e++) step();
    tg.div_load = 1'b1;
    tg.div_val  = 8'd4;
    step();
    tg.div_load = 1'b0;
    n_cmp++;
    if ({tg.clk_stb, tg.sq, tg.div_err} !== 3'b000) begin
      n_err++;
      $display("FAIL load4_edge: got stb/sq/err=%b required 000", {tg.clk_stb, tg.sq, tg.div_err});
    end
    exp_sq = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      step();
      exp_stb = RT ? (j % 4 == 0) : (j == 2 || j == 12);
      if (exp_stb) exp_sq = ~exp_sq;
      n_cmp++;
      if ({tg.clk_stb, tg.sq, tg.div_err} !== {exp_stb, exp_sq, 1'b0}) begin
        n_err++;
        $display("FAIL load4_run edge %0d: got stb/sq/err=%b required %b", j, {tg.clk_stb, tg.sq, tg.div_err}, {exp_stb, exp_sq, 1'b0});
      end
    end
    tg.div_load = 1'b1;
    tg.div_val  = 8'd1;
    step();
    tg.div_load = 1'b0;
    n_cmp++;
    if ({tg.clk_stb, tg.div_err} !== {1'b0, RT}) begin
      n_err++;
      $display("FAIL load1_err: got stb/err=%b required %b", {tg.clk_stb, tg.div_err}, {1'b0, RT});
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_stb = RT ? (k == 3) : (k == 9);
      n_cmp++;
      if ({tg.clk_stb, tg.div_err} !== {exp_stb, 1'b0}) begin
        n_err++;
        $display("FAIL load1_run edge %0d: got stb/err=%b required %b", k, {tg.clk_stb, tg.div_err}, {exp_stb, 1'b0});
      end
    end
  endtask

  task automatic test_sync_load();
    logic exp_stb;
    do_reset();
    tg.en = 1'b1;
    for (int e = 1; e <= 19; e++) step();
    tg.sync     = 1'b1;
    tg.div_load = 1'b1;
    tg.div_val  = 8'd2;
    step();
    tg.sync     = 1'b0;
    tg.div_load = 1'b0;
    n_cmp++;
    if ({tg.clk_stb, tg.sq, tg.div_err} !== 3'b000) begin
      n_err++;
      $display("FAIL sync_load_edge: got stb/sq/err=%b required 000", {tg.clk_stb, tg.sq, tg.div_err});
    end
    for (int j = 1; j <= 10; j++) begin
      step();
      exp_stb = RT ? (j % 2 == 0) : (j == 10);
      n_cmp++;
      if (tg.clk_stb !== exp_stb) begin
        n_err++;
        $display("FAIL sync_load_run edge %0d: got %b required %b", j, tg.clk_stb, exp_stb);
      end
    end
  endtask

  task automatic test_reset_mid();
    int wait_edges;
    wait_edges = RT ? 4 : 9;
    do_reset();
    tg.en       = 1'b1;
    tg.div_load = 1'b1;
    tg.div_val  = 8'd4;
    step();
    tg.div_load = 1'b0;
    for (int e = 1; e <= wait_edges; e++) step();
    n_cmp++;
    if ({tg.clk_stb, tg.sq} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_mid_pre: got stb/sq=%b required 11", {tg.clk_stb, tg.sq});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tg.clk_stb, tg.sq, tg.div_err} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_mid_async: got stb/sq/err=%b required 000", {tg.clk_stb, tg.sq, tg.div_err});
    end
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      step();
      n_cmp++;
      if (tg.clk_stb !== (e == 10)) begin
        n_err++;
        $display("FAIL reset_mid_period edge %0d: got %b required %b", e, tg.clk_stb, (e == 10));
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    test_reset();
    test_count();
    test_enable();
    test_sync();
    test_runtime_div();
    test_sync_load();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
